// File: rtl/mem_stage.sv
// mem_stage: pipeline stage after execute. Registers the EXE results, drives a
// req/ack data-memory bus with byte-lane formatting, produces write-back data,
// register write enable and destination for WB, and stalls upstream while a
// memory access is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   - an access with no ack for TIMEOUT_CYCLES stall cycles is
//               aborted, and o_MEM_busErr is set until reset.
//   undefined - the stage waits indefinitely and o_MEM_busErr is tied 0.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   i_MEM_dmemWe/regWe/sByte  store, register write, byte access
//   i_MEM_sWRD, i_MEM_WRA     write-back from memory, destination register
//   i_MEM_rd2, i_MEM_aluOut   store data, ALU result / effective address
//   i_MEM_dRdata, i_MEM_dAck  memory read data and completion
//   o_MEM_dReq/dWe/dAddr      memory request, write flag, word address
//   o_MEM_dWdata, o_MEM_dBe   write data and byte enables
//   o_MEM_regWe/WRA/wbData    write-back controls and data to WB
//   o_MEM_aluOut              registered ALU result for forwarding
//   o_MEM_stall               freeze upstream stages and PC
//   o_MEM_busErr              sticky timeout flag
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_MEM_dmemWe,
   input  logic        i_MEM_regWe,
   input  logic        i_MEM_sByte,
   input  logic        i_MEM_sWRD,
   input  logic [4:0]  i_MEM_WRA,
   input  logic [31:0] i_MEM_rd2,
   input  logic [31:0] i_MEM_aluOut,
   input  logic [31:0] i_MEM_dRdata,
   input  logic        i_MEM_dAck,
   output logic        o_MEM_dReq,
   output logic        o_MEM_dWe,
   output logic [31:0] o_MEM_dAddr,
   output logic [31:0] o_MEM_dWdata,
   output logic [3:0]  o_MEM_dBe,
   output logic        o_MEM_regWe,
   output logic [4:0]  o_MEM_WRA,
   output logic [31:0] o_MEM_wbData,
   output logic [31:0] o_MEM_aluOut,
   output logic        o_MEM_stall,
   output logic        o_MEM_busErr
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RA_W = 5;
   localparam int unsigned BE_W = 4;

   // Stage register contents
   logic            dmem_we_q;
   logic            reg_we_q;
   logic            s_byte_q;
   logic            s_wrd_q;
   logic [RA_W-1:0] wra_q;
   logic [XLEN-1:0] rd2_q;
   logic [XLEN-1:0] alu_q;
   logic            pending;

   logic            load;
   logic            memop_in;
   logic            timeout_hit;
   logic            abort_q;
   logic [1:0]      lane;
   logic [7:0]      rd_byte;

   // Outstanding access that has not been acked this cycle holds the pipe
   assign o_MEM_stall = pending & ~i_MEM_dAck;
   assign load        = ~o_MEM_stall;
   assign memop_in    = i_MEM_dmemWe | i_MEM_sWRD;
   assign lane        = alu_q[1:0];

   // Stage register and request-pending flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dmem_we_q <= 1'b0;
         reg_we_q  <= 1'b0;
         s_byte_q  <= 1'b0;
         s_wrd_q   <= 1'b0;
         wra_q     <= '0;
         rd2_q     <= '0;
         alu_q     <= '0;
         pending   <= 1'b0;
      end else if (load) begin
         dmem_we_q <= i_MEM_dmemWe;
         reg_we_q  <= i_MEM_regWe;
         s_byte_q  <= i_MEM_sByte;
         s_wrd_q   <= i_MEM_sWRD;
         wra_q     <= i_MEM_WRA;
         rd2_q     <= i_MEM_rd2;
         alu_q     <= i_MEM_aluOut;
         // An ack and a new memop on the same edge keep the request alive
         pending   <= memop_in;
      end else if (timeout_hit) begin
         pending   <= 1'b0;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;
   logic             bus_err_q;

   // Last permitted stall cycle without ack: abort on the closing edge
   assign timeout_hit = o_MEM_stall &
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Wait counter, abort marker and sticky bus error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt  <= '0;
         abort_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         abort_q <= timeout_hit;
         if (timeout_hit) begin
            bus_err_q <= 1'b1;
         end
         if (load) begin
            wait_cnt <= '0;
         end else if (o_MEM_stall) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   assign o_MEM_busErr = bus_err_q;
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign abort_q            = 1'b0;
   assign o_MEM_busErr       = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Little-endian lane select from the returned word
   always_comb begin
      rd_byte = i_MEM_dRdata[7:0];
      case (lane)
         2'd0:    rd_byte = i_MEM_dRdata[7:0];
         2'd1:    rd_byte = i_MEM_dRdata[15:8];
         2'd2:    rd_byte = i_MEM_dRdata[23:16];
         default: rd_byte = i_MEM_dRdata[31:24];
      endcase
   end

   // Write-back data: memory for loads (store wins if both flags set), else ALU
   always_comb begin
      o_MEM_wbData = alu_q;
      if (s_wrd_q && !dmem_we_q) begin
         if (s_byte_q) begin
            o_MEM_wbData = {{(XLEN - 8){rd_byte[7]}}, rd_byte};
         end else begin
            o_MEM_wbData = i_MEM_dRdata;
         end
      end
   end

   // Bus payload is derived from the held stage register, so it stays stable
   // for as long as the request is pending
   always_comb begin
      o_MEM_dBe    = '0;
      o_MEM_dWdata = rd2_q;
      if (s_byte_q) begin
         o_MEM_dWdata = {4{rd2_q[7:0]}};
      end
      if (pending) begin
         o_MEM_dBe = s_byte_q ? BE_W'(4'b0001 << lane) : BE_W'(4'hF);
      end
   end

   assign o_MEM_dReq   = pending;
   assign o_MEM_dWe    = pending & dmem_we_q;
   assign o_MEM_dAddr  = {alu_q[XLEN-1:2], 2'b00};
   assign o_MEM_aluOut = alu_q;
   assign o_MEM_WRA    = wra_q;
   // WB sees a bubble while stalled or in the cycle after an aborted access
   assign o_MEM_regWe  = reg_we_q & ~o_MEM_stall & ~abort_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. A transaction-level model (the
// instruction currently in the stage plus whether it is acked this cycle)
// predicts every output each cycle; literal per-instruction expectations pin
// the model on the ack cycle.
module tb_mem_stage;

   typedef struct {
      logic        we;
      logic        rwe;
      logic        sbyte;
      logic        swrd;
      logic [4:0]  wra;
      logic [31:0] rd2;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          waits;
      bit          spur;
      logic [31:0] l_wb;
      logic [31:0] l_addr;
      logic [31:0] l_wdata;
      logic [3:0]  l_be;
   } instr_t;

   logic        clk;
   logic        rstn;
   logic        i_MEM_dmemWe;
   logic        i_MEM_regWe;
   logic        i_MEM_sByte;
   logic        i_MEM_sWRD;
   logic [4:0]  i_MEM_WRA;
   logic [31:0] i_MEM_rd2;
   logic [31:0] i_MEM_aluOut;
   logic [31:0] i_MEM_dRdata;
   logic        i_MEM_dAck;
   logic        o_MEM_dReq;
   logic        o_MEM_dWe;
   logic [31:0] o_MEM_dAddr;
   logic [31:0] o_MEM_dWdata;
   logic [3:0]  o_MEM_dBe;
   logic        o_MEM_regWe;
   logic [4:0]  o_MEM_WRA;
   logic [31:0] o_MEM_wbData;
   logic [31:0] o_MEM_aluOut;
   logic        o_MEM_stall;
   logic        o_MEM_busErr;

   int     n_pass  = 0;
   int     n_total = 0;
   bit     chk_en  = 0;
   bit     ack_now = 0;
   bit     err_exp = 0;
   instr_t cur;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_MEM_dmemWe (i_MEM_dmemWe),
      .i_MEM_regWe  (i_MEM_regWe),
      .i_MEM_sByte  (i_MEM_sByte),
      .i_MEM_sWRD   (i_MEM_sWRD),
      .i_MEM_WRA    (i_MEM_WRA),
      .i_MEM_rd2    (i_MEM_rd2),
      .i_MEM_aluOut (i_MEM_aluOut),
      .i_MEM_dRdata (i_MEM_dRdata),
      .i_MEM_dAck   (i_MEM_dAck),
      .o_MEM_dReq   (o_MEM_dReq),
      .o_MEM_dWe    (o_MEM_dWe),
      .o_MEM_dAddr  (o_MEM_dAddr),
      .o_MEM_dWdata (o_MEM_dWdata),
      .o_MEM_dBe    (o_MEM_dBe),
      .o_MEM_regWe  (o_MEM_regWe),
      .o_MEM_WRA    (o_MEM_WRA),
      .o_MEM_wbData (o_MEM_wbData),
      .o_MEM_aluOut (o_MEM_aluOut),
      .o_MEM_stall  (o_MEM_stall),
      .o_MEM_busErr (o_MEM_busErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   function automatic instr_t mk(input logic we, input logic rwe, input logic sbyte,
                                 input logic swrd, input logic [4:0] wra,
                                 input logic [31:0] rd2, input logic [31:0] alu,
                                 input logic [31:0] rdata, input int waits, input bit spur,
                                 input logic [31:0] l_wb, input logic [31:0] l_addr,
                                 input logic [31:0] l_wdata, input logic [3:0] l_be);
      instr_t x;
      x.we = we; x.rwe = rwe; x.sbyte = sbyte; x.swrd = swrd; x.wra = wra;
      x.rd2 = rd2; x.alu = alu; x.rdata = rdata; x.waits = waits; x.spur = spur;
      x.l_wb = l_wb; x.l_addr = l_addr; x.l_wdata = l_wdata; x.l_be = l_be;
      return x;
   endfunction

   // Model: what an instruction should produce, from its fields alone
   function automatic bit is_mem(input instr_t x);
      return (x.we || x.swrd);
   endfunction

   function automatic logic [31:0] exp_wb(input instr_t x);
      int unsigned b;
      if (x.swrd && !x.we) begin
         if (x.sbyte) begin
            b = (x.rdata >> (8 * (x.alu % 4))) & 32'hFF;
            return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         end
         return x.rdata;
      end
      return x.alu;
   endfunction

   function automatic logic [31:0] exp_wdata(input instr_t x);
      return x.sbyte ? (32'(x.rd2 & 32'hFF) * 32'h01010101) : x.rd2;
   endfunction

   function automatic logic [3:0] exp_be(input instr_t x);
      return x.sbyte ? 4'(1 << (x.alu % 4)) : 4'hF;
   endfunction

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         bit m;
         bit st;
         m  = is_mem(cur);
         st = m && !ack_now;
         check("dReq",   32'(o_MEM_dReq),   32'(m));
         check("dWe",    32'(o_MEM_dWe),    32'(m && cur.we));
         check("stall",  32'(o_MEM_stall),  32'(st));
         check("regWe",  32'(o_MEM_regWe),  32'(cur.rwe && !st));
         check("WRA",    32'(o_MEM_WRA),    32'(cur.wra));
         check("aluOut", o_MEM_aluOut,      cur.alu);
         check("busErr", 32'(o_MEM_busErr), 32'(err_exp));
         if (!st) check("wbData", o_MEM_wbData, exp_wb(cur));
         if (m) begin
            check("dAddr",  o_MEM_dAddr,       cur.alu & ~32'h3);
            check("dBe",    32'(o_MEM_dBe),    32'(exp_be(cur)));
            check("dWdata", o_MEM_dWdata,      exp_wdata(cur));
         end
      end
   end

   task automatic drive(input instr_t x);
      i_MEM_dmemWe = x.we;
      i_MEM_regWe  = x.rwe;
      i_MEM_sByte  = x.sbyte;
      i_MEM_sWRD   = x.swrd;
      i_MEM_WRA    = x.wra;
      i_MEM_rd2    = x.rd2;
      i_MEM_aluOut = x.alu;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   instr_t prog[9];
   instr_t nop;
   instr_t rl;

   initial begin
      nop = mk(0,0,0,0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0);
      //           we rwe sb swrd wra  rd2           alu          rdata        w  sp  l_wb          l_addr       l_wdata       l_be
      prog[0] = mk(1, 0, 0, 0, 5'd0,  32'hDEADBEEF, 32'h100, 32'h0,        0, 0, 32'h100,      32'h100, 32'hDEADBEEF, 4'hF);
      prog[1] = mk(0, 1, 1, 1, 5'd5,  32'h0,        32'h203, 32'h80FFFFFF, 3, 0, 32'hFFFFFF80, 32'h200, 32'h0,        4'b1000);
      prog[2] = mk(1, 0, 1, 0, 5'd0,  32'hA5,       32'h11,  32'h0,        1, 0, 32'h11,       32'h10,  32'hA5A5A5A5, 4'b0010);
      prog[3] = mk(0, 1, 0, 1, 5'd7,  32'h0,        32'h400, 32'h12345678, 0, 0, 32'h12345678, 32'h400, 32'h0,        4'hF);
      prog[4] = mk(0, 1, 0, 1, 5'd8,  32'h55,       32'h404, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 32'h404, 32'h55,       4'hF);
      prog[5] = mk(0, 1, 1, 1, 5'd6,  32'h0,        32'h501, 32'h00007F00, 2, 0, 32'h7F,       32'h500, 32'h0,        4'b0010);
      prog[6] = mk(0, 1, 0, 0, 5'd3,  32'h0,        32'h1234,32'hFFFFFFFF, 0, 1, 32'h1234,     32'h0,   32'h0,        4'h0);
      prog[7] = mk(1, 0, 0, 1, 5'd0,  32'h11223344, 32'h608, 32'hFFFFFFFF, 1, 0, 32'h608,      32'h608, 32'h11223344, 4'hF);
      prog[8] = mk(0, 1, 1, 1, 5'd9,  32'h0,        32'h702, 32'h00AB0000, 0, 0, 32'hFFFFFFAB, 32'h700, 32'h0,        4'b0100);
      rl      = mk(0, 1, 0, 1, 5'd4,  32'h0,        32'h800, 32'h0BADF00D, 0, 0, 32'h0,        32'h0,   32'h0,        4'h0);

      cur = nop;
      rstn = 1'b0;
      drive(nop);
      i_MEM_dRdata = 32'h0;
      i_MEM_dAck   = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst dReq",   32'(o_MEM_dReq),   32'h0);
      check("rst dWe",    32'(o_MEM_dWe),    32'h0);
      check("rst dAddr",  o_MEM_dAddr,       32'h0);
      check("rst dWdata", o_MEM_dWdata,      32'h0);
      check("rst dBe",    32'(o_MEM_dBe),    32'h0);
      check("rst regWe",  32'(o_MEM_regWe),  32'h0);
      check("rst WRA",    32'(o_MEM_WRA),    32'h0);
      check("rst wbData", o_MEM_wbData,      32'h0);
      check("rst aluOut", o_MEM_aluOut,      32'h0);
      check("rst stall",  32'(o_MEM_stall),  32'h0);
      check("rst busErr", 32'(o_MEM_busErr), 32'h0);
      step();
      rstn = 1'b1;
      chk_en = 1;

      // Directed program
      drive(prog[0]);
      step();
      cur = prog[0];
      for (int k = 0; k < 9; k++) begin
         instr_t nxt;
         int nst;
         bit m;
         nxt = (k + 1 < 9) ? prog[k + 1] : nop;
         drive(nxt);
         i_MEM_dRdata = cur.rdata;
         m = is_mem(cur);
         nst = 0;
         if (m) begin
            for (int w = 0; w < cur.waits; w++) begin
               i_MEM_dAck = 1'b0;
               ack_now = 0;
               @(negedge clk);
               if (o_MEM_stall) nst++;
               step();
            end
            check($sformatf("stall_cycles[%0d]", k), 32'(nst), 32'(cur.waits));
            i_MEM_dAck = 1'b1;
            ack_now = 1;
         end else begin
            i_MEM_dAck = cur.spur;
            ack_now = cur.spur;
         end
         @(negedge clk);
         check($sformatf("lit wb[%0d]", k),    o_MEM_wbData,      cur.l_wb);
         check($sformatf("lit regWe[%0d]", k), 32'(o_MEM_regWe),  32'(cur.rwe));
         check($sformatf("lit dReq[%0d]", k),  32'(o_MEM_dReq),   32'(m));
         if (m) begin
            check($sformatf("lit addr[%0d]", k),  o_MEM_dAddr,    cur.l_addr);
            check($sformatf("lit wdata[%0d]", k), o_MEM_dWdata,   cur.l_wdata);
            check($sformatf("lit be[%0d]", k),    32'(o_MEM_dBe), 32'(cur.l_be));
         end
         step();
         cur = nxt;
         i_MEM_dAck = 1'b0;
         ack_now = 0;
      end
      step();

      // Reset while an access is waiting for its ack
      drive(rl);
      step();
      cur = rl;
      i_MEM_dRdata = rl.rdata;
      drive(nop);
      step();
      step();
      chk_en = 0;
      rstn = 1'b0;
      #1;
      check("midrst dReq",  32'(o_MEM_dReq),  32'h0);
      check("midrst stall", 32'(o_MEM_stall), 32'h0);
      check("midrst regWe", 32'(o_MEM_regWe), 32'h0);
      step();
      rstn = 1'b1;
      cur = nop;
      chk_en = 1;
      step();
      step();

`ifdef MEM_TIMEOUT_EN
      // Access never acked: aborted after four stall cycles
      begin
         int nst;
         nst = 0;
         drive(rl);
         step();
         chk_en = 0;
         drive(nop);
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!o_MEM_stall) break;
            nst++;
            step();
         end
         check("to stall_cycles", 32'(nst),          32'd4);
         check("to regWe",        32'(o_MEM_regWe),  32'h0);
         check("to dReq",         32'(o_MEM_dReq),   32'h0);
         check("to busErr",       32'(o_MEM_busErr), 32'h1);
         step();
         step();
         @(negedge clk);
         check("to busErr sticky", 32'(o_MEM_busErr), 32'h1);
         check("to after stall",   32'(o_MEM_stall),  32'h0);
      end
`endif

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
